out_port_ctrl: RTL
==================

OUT_PORT_CTRL -- requirements
Module: out_port_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered output words; power of two, 2..16.
REQ-002 Parameter: WIDTH, 32, data word width.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: clear  input  1  synchronous, active-high reset.
REQ-005 Port: OutPortin  input  1  CPU write strobe; sampled on each rising edge.
REQ-006 Port: BusMuxOut  input  WIDTH  CPU bus data, captured when OutPortin=1.
REQ-007 Port: dev_ack  input  1  external device acknowledge (4-phase).
REQ-008 Port: OutPortData  output  WIDTH  registered data presented to the device.
REQ-009 Port: out_req  output  1  registered request to the device (4-phase).
REQ-010 Port: out_stall  output  1  buffer full; the control unit must hold the write.
REQ-011 Port: overflow  output  1  sticky flag; a write was dropped.
REQ-012 Port: fifo_count  output  $clog2(DEPTH)+1  number of words buffered.

Function
REQ-013 Buffer: FIFO of DEPTH words; push = OutPortin accepted; pop = head loaded into OutPortData.
REQ-014 Push accepted when fifo_count<DEPTH, or when fifo_count==DEPTH and a pop occurs in the same cycle.
REQ-015 Write with fifo_count==DEPTH and no same-cycle pop: word dropped, FIFO unchanged, overflow set to 1 on that edge.
REQ-016 out_stall = (fifo_count==DEPTH), derived combinationally from the registered count only.
REQ-017 FSM states: IDLE, REQ, RELEASE.
REQ-018 IDLE->REQ when fifo_count>0 and dev_ack==0; on that edge OutPortData<=head, pop, out_req<=1.
REQ-019 IDLE with dev_ack==1 or an empty FIFO: remain in IDLE, no pop.
REQ-020 REQ->RELEASE when dev_ack==1; out_req<=0 on that edge; OutPortData held throughout REQ.
REQ-021 RELEASE->IDLE when dev_ack==0; otherwise remain in RELEASE.
REQ-022 OutPortData retains the last transferred word in RELEASE and IDLE until the next pop.
REQ-023 Latency: write accepted at edge N into an empty FIFO in IDLE with dev_ack=0 -> OutPortData and out_req=1 valid after edge N+1.
REQ-024 Same-cycle push and pop: fifo_count unchanged; FIFO order preserved (strict FIFO).
REQ-025 Pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH and never underflows.
REQ-026 Minimum transfer period: 3 cycles per word (IDLE, REQ, RELEASE), given immediate device acknowledge.

Reset
REQ-027 clear=1 at an edge: state<=IDLE, out_req<=0, OutPortData<=0, fifo_count<=0, pointers<=0, overflow<=0.
REQ-028 clear takes priority over OutPortin and dev_ack in the same cycle; a write during clear is discarded.
REQ-029 clear during REQ or RELEASE: out_req drops on the same edge and the pending transfer is abandoned; the next transfer after reset requires dev_ack==0.
REQ-030 overflow is cleared only by clear.

Structure
REQ-031 Package out_port_pkg: FSM state enum (IDLE, REQ, RELEASE), DEPTH and WIDTH defaults, count-width function.
REQ-032 Sub-module out_port_fifo (synchronous FIFO with push, pop, head, count): instantiated once. FSM and output registers reside in out_port_ctrl.

Verification
REQ-033 Single write 0xDEADBEEF, dev_ack responds 1 cycle after req -> OutPortData=0xDEADBEEF and out_req=1 one edge after the write; req drops after ack; FSM returns to IDLE; fifo_count=0.
REQ-034 Four back-to-back writes 1,2,3,4 with dev_ack held 0 -> first word popped; fifo_count peaks at 3; out_stall=0. Then ack cycles -> device receives 1,2,3,4 in order.
REQ-035 DEPTH+2 writes with dev_ack stuck 0 -> out_stall=1 at count 4; the sixth write is dropped; overflow=1 and stays 1; subsequently delivered words are 1..5.
REQ-036 Full FIFO in IDLE, write in the same cycle as a pop -> write accepted; fifo_count remains 4; overflow remains 0.
REQ-037 clear asserted while out_req=1 and fifo_count=2 -> next edge: out_req=0, OutPortData=0, fifo_count=0, overflow=0; a new write after clear is delivered normally.
REQ-038 dev_ack held 1 in IDLE with data buffered -> no req until ack=0, then req on the following edge.

Source files
------------

// File: rtl/out_port_pkg.sv
// out_port_pkg: shared types, defaults and sizing helper for the output port controller.
package out_port_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_WIDTH = 32;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/out_port_fifo.sv
// out_port_fifo: synchronous FIFO; caller guarantees push only when space (or same-cycle pop) and pop only when non-empty.
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          head,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    always_ff @(posedge clock) begin
        if (push) r_mem[r_wp] <= din;
    end
    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wp <= r_wp + 1'b1;
            if (pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end
    assign head  = r_mem[r_rp];
    assign count = r_count;
endmodule

// File: rtl/out_port_ctrl.sv
// out_port_ctrl: buffers CPU output-port writes and hands them to a device over a 4-phase req/ack handshake.
module out_port_ctrl
    import out_port_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      OutPortin,
    input  logic [WIDTH-1:0]          BusMuxOut,
    input  logic                      dev_ack,
    output logic [WIDTH-1:0]          OutPortData,
    output logic                      out_req,
    output logic                      out_stall,
    output logic                      overflow,
    output logic [cnt_w(DEPTH)-1:0]   fifo_count
);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    state_t           r_state;
    logic [WIDTH-1:0] w_head;
    logic             w_pop;
    logic             w_push;
    assign out_stall = fifo_count == FULL;
    assign w_pop     = r_state == IDLE && fifo_count != '0 && !dev_ack;
    // a full FIFO still accepts a write when the head leaves on the same edge
    assign w_push    = OutPortin && (!out_stall || w_pop);
    out_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (BusMuxOut),
        .head  (w_head),
        .count (fifo_count)
    );
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= IDLE;
            out_req     <= 1'b0;
            OutPortData <= '0;
            overflow    <= 1'b0;
        end else begin
            if (OutPortin && !w_push) overflow <= 1'b1;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_state     <= REQ;
                    out_req     <= 1'b1;
                    OutPortData <= w_head;
                end
                REQ: if (dev_ack) begin
                    r_state <= RELEASE;
                    out_req <= 1'b0;
                end
                RELEASE: if (!dev_ack) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
